// File: rtl/chip8_pkg.sv
// Shared scan-code constants, keypad FSM states and the PS/2-to-CHIP-8 key map.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
package chip8_pkg;

  localparam logic [7:0] SC_BREAK  = 8'hF0;
  localparam logic [7:0] SC_EXT    = 8'hE0;
  localparam logic [7:0] SC_BAT    = 8'hAA;
  localparam logic [7:0] SC_ACK    = 8'hFA;
  localparam logic [7:0] SC_RESEND = 8'hFE;
  localparam logic [7:0] SC_OVR0   = 8'h00;
  localparam logic [7:0] SC_OVR1   = 8'hFF;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BRK,
    ST_EXT,
    ST_EXT_BRK
  } kp_state_t;

  // {valid, key}: valid=0 means the scan code is not a keypad key
  typedef struct packed {
    logic       vld;
    logic [3:0] key;
  } key_lookup_t;

  function automatic key_lookup_t sc_to_key(input logic [7:0] sc);
    key_lookup_t r;
    r.vld = 1'b1;
    r.key = 4'h0;
    case (sc)
      8'h16: r.key = 4'h1;
      8'h1E: r.key = 4'h2;
      8'h26: r.key = 4'h3;
      8'h25: r.key = 4'hC;
      8'h15: r.key = 4'h4;
      8'h1D: r.key = 4'h5;
      8'h24: r.key = 4'h6;
      8'h2D: r.key = 4'hD;
      8'h1C: r.key = 4'h7;
      8'h1B: r.key = 4'h8;
      8'h23: r.key = 4'h9;
      8'h2B: r.key = 4'hE;
      8'h1A: r.key = 4'hA;
      8'h22: r.key = 4'h0;
      8'h21: r.key = 4'hB;
      8'h2A: r.key = 4'hF;
      default: r.vld = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/ps2_keypad_if.sv
// Bundle between the PS/2 byte source / CPU side and the keypad decoder.
// Latency: n/a (wires only).
// Backpressure: none; bytes are strobed by ps2_ready and cannot be stalled.
interface ps2_keypad_if;
  logic        ps2_ready;
  logic [7:0]  ps2_data;
  logic        clear;
  logic [15:0] key_matrix;
  logic        key_any;
  logic        key_event;
  logic [3:0]  key_code;

  modport master (
    output ps2_ready, ps2_data, clear,
    input  key_matrix, key_any, key_event, key_code
  );

  modport slave (
    input  ps2_ready, ps2_data, clear,
    output key_matrix, key_any, key_event, key_code
  );
endinterface

// File: rtl/sync_edge.sv
// Multi-flop synchronizer for an asynchronous strobe plus a rising-edge pulse.
// Latency: pulse is high in the cycle after the STAGES-th sampling edge.
// Backpressure: none; one pulse per low-to-high transition. STAGES must be >= 2.
module sync_edge #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic res,
  input  logic din,
  output logic pulse
);

  logic [STAGES-1:0] sync_q;
  logic              last_q;

  // shift the async input through the synchronizer and remember the last synced level
  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      sync_q <= '0;
      last_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], din};
      last_q <= sync_q[STAGES-1];
    end
  end

  assign pulse = sync_q[STAGES-1] & ~last_q;

endmodule

// File: rtl/ps2_keypad.sv
// PS/2 scan-code stream to 16-key CHIP-8 matrix with key-down event pulse.
// Latency: SYNC_STAGES+2 clk from ps2_ready rising to key_matrix/key_event update.
// Backpressure: none; bytes arriving while clear is high are dropped.
module ps2_keypad
  import chip8_pkg::*;
#(
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 20000
) (
  input  logic clk,
  input  logic res,
  ps2_keypad_if.slave kp
);

  localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT_CYCLES - 1);

  logic        rdy_pulse;
  logic [7:0]  byte_q;
  logic        byte_vld;
  kp_state_t   state_q, state_d;
  logic [CW-1:0] cnt_q;
  logic [15:0] matrix_q, matrix_d;
  logic        any_q;
  logic        evt_q, evt_d;
  logic [3:0]  code_q, code_d;
  key_lookup_t lk;
  logic        status_byte;
  logic        timeout;

  sync_edge #(.STAGES(SYNC_STAGES)) u_sync (
    .clk   (clk),
    .res   (res),
    .din   (kp.ps2_ready),
    .pulse (rdy_pulse)
  );

  // capture the byte on the synchronized rising edge; decode happens one cycle later
  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      byte_q   <= 8'h00;
      byte_vld <= 1'b0;
    end else begin
      byte_vld <= rdy_pulse;
      if (rdy_pulse) byte_q <= kp.ps2_data;
    end
  end

  assign lk          = sc_to_key(byte_q);
  // BAT/ack/resend never map to a key, so excluding them only documents intent
  assign status_byte = (byte_q == SC_BAT) || (byte_q == SC_ACK) || (byte_q == SC_RESEND);
  assign timeout     = (state_q != ST_IDLE) && (cnt_q == TMO_LAST);

  // prefix FSM and matrix update; clear beats a byte, a byte beats a timeout
  always_comb begin
    state_d  = state_q;
    matrix_d = matrix_q;
    evt_d    = 1'b0;
    code_d   = code_q;
    if (kp.clear) begin
      state_d  = ST_IDLE;
      matrix_d = '0;
    end else if (byte_vld) begin
      unique case (state_q)
        ST_IDLE: begin
          if (byte_q == SC_BREAK) begin
            state_d = ST_BRK;
          end else if (byte_q == SC_EXT) begin
            state_d = ST_EXT;
          end else if (byte_q == SC_OVR0 || byte_q == SC_OVR1) begin
            matrix_d = '0;
          end else if (lk.vld && !status_byte) begin
            matrix_d[lk.key] = 1'b1;
            // a repeat of an already-held key is typematic and raises no event
            if (!matrix_q[lk.key]) begin
              evt_d  = 1'b1;
              code_d = lk.key;
            end
          end
        end
        ST_BRK: begin
          if (lk.vld) matrix_d[lk.key] = 1'b0;
          state_d = ST_IDLE;
        end
        ST_EXT: begin
          // extended keys are swallowed so they never alias onto keypad keys
          state_d = (byte_q == SC_BREAK) ? ST_EXT_BRK : ST_IDLE;
        end
        ST_EXT_BRK: begin
          state_d = ST_IDLE;
        end
      endcase
    end else if (timeout) begin
      state_d = ST_IDLE;
    end
  end

  // state and registered outputs; key_any comes from the same next-state matrix
  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      state_q  <= ST_IDLE;
      matrix_q <= '0;
      any_q    <= 1'b0;
      evt_q    <= 1'b0;
      code_q   <= 4'h0;
    end else begin
      state_q  <= state_d;
      matrix_q <= matrix_d;
      any_q    <= |matrix_d;
      evt_q    <= evt_d;
      code_q   <= code_d;
    end
  end

  // prefix timeout counter: restarts on every byte, clear and state entry
  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      cnt_q <= '0;
    end else if (kp.clear || byte_vld || state_d == ST_IDLE || state_d != state_q) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + CW'(1);
    end
  end

  assign kp.key_matrix = matrix_q;
  assign kp.key_any    = any_q;
  assign kp.key_event  = evt_q;
  assign kp.key_code   = code_q;

endmodule

// File: tb/tb_ps2_keypad.sv
// Self-checking bench for ps2_keypad: directed scenarios then randomized bytes.
// Expected values come from a behavioural model keyed on the key map table.
// Events are collected by a negedge monitor and compared after each byte.
module tb_ps2_keypad;

  localparam int S = 2;
  localparam int T = 200;

  logic clk = 1'b0;
  logic res;
  always #5 clk = ~clk;

  ps2_keypad_if kp();

  ps2_keypad #(.SYNC_STAGES(S), .TIMEOUT_CYCLES(T)) dut (
    .clk (clk),
    .res (res),
    .kp  (kp)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // key n is produced by scan code keymap[n]
  logic [7:0] keymap [16] = '{8'h22, 8'h16, 8'h1E, 8'h26, 8'h15, 8'h1D, 8'h24, 8'h1C,
                              8'h1B, 8'h23, 8'h1A, 8'h21, 8'h25, 8'h2D, 8'h2B, 8'h2A};

  // model state
  logic [15:0] m_mat;
  logic [3:0]  m_code;
  bit          p_brk, p_ext;
  int          exp_q[$];

  // observed events
  int   ev_q[$];
  logic prev_ev = 1'b0;
  int   consec = 0;

  always @(negedge clk) begin
    if (kp.key_event === 1'b1) begin
      ev_q.push_back(int'(kp.key_code));
      if (prev_ev === 1'b1) consec++;
    end
    prev_ev = kp.key_event;
  end

  function automatic int lookup(input logic [7:0] d);
    for (int i = 0; i < 16; i++) if (keymap[i] == d) return i;
    return -1;
  endfunction

  task automatic model_byte(input logic [7:0] d);
    int k;
    k = lookup(d);
    if (p_ext) begin
      if (!p_brk && d == 8'hF0) p_brk = 1'b1;
      else begin p_ext = 1'b0; p_brk = 1'b0; end
    end else if (p_brk) begin
      if (k >= 0) m_mat[k] = 1'b0;
      p_brk = 1'b0;
    end else if (d == 8'hF0) p_brk = 1'b1;
    else if (d == 8'hE0) p_ext = 1'b1;
    else if (d == 8'h00 || d == 8'hFF) m_mat = '0;
    else if (k >= 0) begin
      if (!m_mat[k]) begin
        exp_q.push_back(k);
        m_code = 4'(k);
      end
      m_mat[k] = 1'b1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, "_mat"}, 32'(kp.key_matrix), 32'(m_mat));
    chk({tag, "_any"}, 32'(kp.key_any), 32'(|m_mat));
    chk({tag, "_nev"}, 32'(ev_q.size()), 32'(exp_q.size()));
    while (ev_q.size() > 0 && exp_q.size() > 0)
      chk({tag, "_evcode"}, 32'(ev_q.pop_front()), 32'(exp_q.pop_front()));
    ev_q.delete();
    exp_q.delete();
    chk({tag, "_code"}, 32'(kp.key_code), 32'(m_code));
  endtask

  task automatic send(input logic [7:0] d);
    @(posedge clk); #1;
    kp.ps2_data  = d;
    kp.ps2_ready = 1'b1;
    repeat (S + 1) @(posedge clk);
    #1 kp.ps2_ready = 1'b0;
    repeat (S + 3) @(posedge clk);
    #1;
    model_byte(d);
  endtask

  task automatic idle_long();
    repeat (T + 20) @(posedge clk);
    #1;
    p_brk = 1'b0;
    p_ext = 1'b0;
  endtask

  task automatic pulse_clear();
    @(posedge clk); #1 kp.clear = 1'b1;
    @(posedge clk); #1 kp.clear = 1'b0;
    m_mat = '0; p_brk = 1'b0; p_ext = 1'b0;
  endtask

  // clear lands exactly on the decode cycle of byte d
  task automatic clear_with_byte(input logic [7:0] d);
    @(posedge clk); #1;
    kp.ps2_data  = d;
    kp.ps2_ready = 1'b1;
    repeat (S + 1) @(posedge clk);
    #1 kp.ps2_ready = 1'b0;
    kp.clear = 1'b1;
    @(posedge clk); #1 kp.clear = 1'b0;
    repeat (S + 3) @(posedge clk);
    #1;
    m_mat = '0; p_brk = 1'b0; p_ext = 1'b0;
  endtask

  task automatic model_reset();
    m_mat = '0; m_code = 4'h0; p_brk = 1'b0; p_ext = 1'b0;
    exp_q.delete();
    ev_q.delete();
  endtask

  initial begin
    logic [7:0] d;
    int r;
    res = 1'b0;
    kp.ps2_ready = 1'b0;
    kp.ps2_data  = 8'h00;
    kp.clear     = 1'b0;
    model_reset();

    // reset state
    #12;
    check_all("reset");
    chk("reset_evt", 32'(kp.key_event), 32'd0);
    @(posedge clk); #1 res = 1'b1;

    // make / repeat / break
    send(8'h16); check_all("make16");
    send(8'h16); check_all("repeat16");
    send(8'hF0); send(8'h16); check_all("break16");

    // multi-key
    send(8'h22); check_all("mk22");
    send(8'h2A); check_all("mk2A");
    send(8'hF0); send(8'h22); check_all("brk22");

    // extended codes ignored
    pulse_clear();
    send(8'hE0); send(8'h1C); check_all("ext1C");
    send(8'hE0); send(8'hF0); send(8'h1C); check_all("extbrk1C");
    send(8'h1C); check_all("plain1C");

    // status bytes and overrun
    pulse_clear();
    send(8'h1E); send(8'hAA); send(8'hFA); check_all("status");
    send(8'h00); check_all("overrun");

    // prefix timeout, then no timeout
    send(8'hF0); idle_long(); send(8'h26); check_all("tmo26");
    send(8'hF0); send(8'h26); check_all("notmo26");

    // reset mid-sequence discards the prefix
    send(8'hF0);
    @(posedge clk); #3 res = 1'b0;
    #1;
    model_reset();
    check_all("midreset");
    chk("midreset_evt", 32'(kp.key_event), 32'd0);
    @(posedge clk); #1 res = 1'b1;
    send(8'h25); check_all("after_reset25");

    // clear coincident with a decode drops the byte
    send(8'h16);
    clear_with_byte(8'h2A); check_all("clear_drop");

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      r = $urandom_range(0, 99);
      if (r < 55)      d = keymap[$urandom_range(0, 15)];
      else if (r < 68) d = 8'hF0;
      else if (r < 76) d = 8'hE0;
      else if (r < 82) begin
        case ($urandom_range(0, 2))
          0:       d = 8'hAA;
          1:       d = 8'hFA;
          default: d = 8'hFE;
        endcase
      end
      else if (r < 85) d = ($urandom_range(0, 1) == 0) ? 8'h00 : 8'hFF;
      else             d = 8'($urandom_range(0, 255));
      send(d);
      check_all("rand");
      r = $urandom_range(0, 99);
      if (r < 5)      idle_long();
      else if (r < 8) pulse_clear();
      else if (r < 10) begin
        clear_with_byte(keymap[$urandom_range(0, 15)]);
        check_all("rand_clrdrop");
      end
    end

    chk("no_back_to_back_events", 32'(consec), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
